// File: rtl/acond_botones.sv
// -----------------------------------------------------------------------------
// acond_botones
//
// Input conditioning for the three board push-buttons (food, medicine, test).
// Each raw button goes through polarity normalisation, a 2-flop synchroniser,
// a debounce counter with a stable-state register, and a rising-edge detector.
// The result is a clean single-cycle press pulse per channel. The test channel
// can additionally be long-press qualified.
//
// Optional feature macro: TEST_LONG_PRESS_EN
//   defined   : Boton_Test pulses once when the debounced test level has been
//               high for LONG_PRESS_CYCLES cycles; no further pulse until the
//               button is released and held again.
//   undefined : Boton_Test pulses on the debounced rising edge, like the other
//               channels, and the hold counter is not built.
//
// Parameters:
//   DEBOUNCE_CYCLES   stable cycles needed to accept a new level (min 2)
//   LONG_PRESS_CYCLES debounced hold length for a test pulse (min 2)
//   ACTIVE_LOW        1 when the raw pins read 0 while pressed
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-high; clears every register
//   Boton_Comida_raw    in   raw food button
//   Boton_Medicina_raw  in   raw medicine button
//   Boton_Test_raw      in   raw test button
//   Boton_Comida        out  one-cycle food press pulse
//   Boton_Medicina      out  one-cycle medicine press pulse
//   Boton_Test          out  one-cycle test pulse
//   test_held           out  debounced level of the test button
//   actividad           out  OR of the three pulses, same timing as them
// -----------------------------------------------------------------------------
module acond_botones #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 250000000,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic Boton_Comida_raw,
    input  logic Boton_Medicina_raw,
    input  logic Boton_Test_raw,
    output logic Boton_Comida,
    output logic Boton_Medicina,
    output logic Boton_Test,
    output logic test_held,
    output logic actividad
);

    // Channel indices into the per-channel vectors.
    localparam int CH_FOOD = 0;
    localparam int CH_MED  = 1;
    localparam int CH_TEST = 2;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the configuration.
    if ((DEBOUNCE_CYCLES < 2) || (LONG_PRESS_CYCLES < 2)) begin : g_bad_param
        $error("acond_botones: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
    end

    // Raw and polarity-normalised buttons, bit order {test, medicine, food}.
    logic [2:0] raw_s;
    logic [2:0] norm_s;

    // Synchroniser stages.
    logic [2:0] s1_q;
    logic [2:0] s1_d;
    logic [2:0] s2_q;
    logic [2:0] s2_d;

    // Debounce state.
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Registered copy of the debounced level; this is the edge register and
    // also drives test_held for the test channel.
    logic [2:0] lvl_q;
    logic [2:0] lvl_d;

    // Previous level for food/medicine rising-edge detection.
    logic [1:0] prev_q;
    logic [1:0] prev_d;

    // Output pulse registers.
    logic [2:0] pulse_q;
    logic [2:0] pulse_d;
    logic       act_q;
    logic       act_d;

`ifdef TEST_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_THR = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Saturating count of cycles the debounced test level has been high.
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
`else
    // Previous test level for plain rising-edge detection.
    logic test_prev_q;
    logic test_prev_d;
`endif

    // Gather raw pins and normalise polarity so 1 always means pressed.
    always_comb begin
        raw_s = {Boton_Test_raw, Boton_Medicina_raw, Boton_Comida_raw};
        if (ACTIVE_LOW != 0) begin
            norm_s = ~raw_s;
        end else begin
            norm_s = raw_s;
        end
    end

    // Two-flop synchroniser next state.
    always_comb begin
        s1_d = norm_s;
        s2_d = s1_q;
    end

    // Debounce: count consecutive cycles the synchronised input disagrees with
    // the accepted level; accept the new level on the DEBOUNCE_CYCLES-th one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Edge detection and pulse generation for all channels.
    always_comb begin
        pulse_d = 3'b000;
        lvl_d   = stable_q;
        prev_d  = lvl_q[1:0];

        pulse_d[CH_FOOD] = lvl_q[CH_FOOD] & ~prev_q[CH_FOOD];
        pulse_d[CH_MED]  = lvl_q[CH_MED]  & ~prev_q[CH_MED];

`ifdef TEST_LONG_PRESS_EN
        // Count while held, clear on release. Saturation above the threshold
        // guarantees the threshold value is crossed only once per hold.
        if (lvl_q[CH_TEST]) begin
            if (hold_q == HOLD_MAX) begin
                hold_d = hold_q;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            hold_d = '0;
        end
        // Fires on the cycle the hold reaches LONG_PRESS_CYCLES.
        pulse_d[CH_TEST] = lvl_q[CH_TEST] & (hold_q == HOLD_THR);
`else
        test_prev_d      = lvl_q[CH_TEST];
        pulse_d[CH_TEST] = lvl_q[CH_TEST] & ~test_prev_q;
`endif

        act_d = |pulse_d;
    end

    // State registers for all channels; everything clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 3'b000;
            s2_q     <= 3'b000;
            stable_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            lvl_q    <= 3'b000;
            prev_q   <= 2'b00;
            pulse_q  <= 3'b000;
            act_q    <= 1'b0;
`ifdef TEST_LONG_PRESS_EN
            hold_q   <= '0;
`else
            test_prev_q <= 1'b0;
`endif
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            lvl_q    <= lvl_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            act_q    <= act_d;
`ifdef TEST_LONG_PRESS_EN
            hold_q   <= hold_d;
`else
            test_prev_q <= test_prev_d;
`endif
        end
    end

    assign Boton_Comida   = pulse_q[CH_FOOD];
    assign Boton_Medicina = pulse_q[CH_MED];
    assign Boton_Test     = pulse_q[CH_TEST];
    assign test_held      = lvl_q[CH_TEST];
    assign actividad      = act_q;

endmodule

// File: tb/tb_acond_botones.sv
// -----------------------------------------------------------------------------
// tb_acond_botones
//
// Two instances run side by side: one active-high, one active-low driven with
// the inverted pins. Both are compared every cycle against a history-based
// reference model, plus fixed-edge expectations for the directed scenarios.
// Honours TEST_LONG_PRESS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_acond_botones;

    localparam int D    = 4;
    localparam int L    = 20;
    localparam int MAXN = 2048;
`ifdef TEST_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
    localparam int TEST_E  = 26;
`else
    localparam bit LONG_EN = 1'b0;
    localparam int TEST_E  = 7;
`endif

    logic clk = 1'b0;
    logic reset;
    logic raw_f, raw_m, raw_t;
    logic inv_f, inv_m, inv_t;
    logic f_a, m_a, t_a, h_a, act_a;
    logic f_b, m_b, t_b, h_b, act_b;
    logic [4:0] obs_a, obs_b, exp_v;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int last_e = 0;

    // Model history: sampled raw level, accepted level, debounced output level.
    bit x_h  [3][MAXN];
    bit st_h [3][MAXN];
    bit hd_h [3][MAXN];

    assign inv_f = ~raw_f;
    assign inv_m = ~raw_m;
    assign inv_t = ~raw_t;
    assign obs_a = {f_a, m_a, t_a, h_a, act_a};
    assign obs_b = {f_b, m_b, t_b, h_b, act_b};

    acond_botones #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .reset(reset),
        .Boton_Comida_raw(raw_f), .Boton_Medicina_raw(raw_m), .Boton_Test_raw(raw_t),
        .Boton_Comida(f_a), .Boton_Medicina(m_a), .Boton_Test(t_a),
        .test_held(h_a), .actividad(act_a)
    );

    acond_botones #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset),
        .Boton_Comida_raw(inv_f), .Boton_Medicina_raw(inv_m), .Boton_Test_raw(inv_t),
        .Boton_Comida(f_b), .Boton_Medicina(m_b), .Boton_Test(t_b),
        .test_held(h_b), .actividad(act_b)
    );

    always #5 clk = ~clk;

    function automatic bit xv(int c, int i);
        return (i < 0) ? 1'b0 : x_h[c][i];
    endfunction

    function automatic bit hv(int c, int i);
        return (i < 0) ? 1'b0 : hd_h[c][i];
    endfunction

    // Model after edge e: level flips once the last D synchronised samples
    // (two edges old) all disagree with it; output level is one edge later;
    // a pulse follows a rise of the output level, or for a long-press test an
    // output-level run of exactly L cycles.
    task automatic model(input int e);
        bit prev, flip, p [3], run;
        for (int c = 0; c < 3; c++) begin
            prev = (e > 0) ? st_h[c][e-1] : 1'b0;
            flip = 1'b1;
            for (int k = 0; k < D; k++) if (xv(c, e - 2 - k) == prev) flip = 1'b0;
            st_h[c][e] = flip ? ~prev : prev;
            hd_h[c][e] = (e > 0) ? st_h[c][e-1] : 1'b0;
            p[c] = hv(c, e - 1) & ~hv(c, e - 2);
        end
        if (LONG_EN) begin
            run = ~hv(2, e - L - 1);
            for (int k = 1; k <= L; k++) if (!hv(2, e - k)) run = 1'b0;
            p[2] = run;
        end
        exp_v = {p[0], p[1], p[2], hv(2, e), p[0] | p[1] | p[2]};
    endtask

    task automatic tick();
        x_h[0][n] = raw_f;
        x_h[1][n] = raw_m;
        x_h[2][n] = raw_t;
        @(posedge clk);
        model(n);
        last_e = n;
        n++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        raw_f = 1'b1; raw_m = 1'b1; raw_t = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs_a !== 5'b00000 || obs_b !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state got hi=%b lo=%b want 00000", obs_a, obs_b);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL reset_release e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
            checks++;
            if (f_a !== (last_e == 7) || m_a !== (last_e == 7) || t_a !== (last_e == TEST_E)) begin
                errors++;
                $display("FAIL reset_release_edge e=%0d got f=%b m=%b t=%b want pulses at 7/7/%0d", last_e, f_a, m_a, t_a, TEST_E);
            end
        end
        // Asynchronous reset in the middle of a cycle, inputs still high.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_a !== 5'b00000 || obs_b !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async got hi=%b lo=%b want 00000", obs_a, obs_b);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_v || obs_b !== exp_v || f_a !== (last_e == 7) || m_a !== (last_e == 7)) begin
                errors++;
                $display("FAIL reset_repress e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
        end
    endtask

    task automatic test_food();
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        apply_reset();
        for (int i = 0; i < 45; i++) begin
            raw_f = (i < 30);
            tick();
            checks++;
            if (obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL food_model e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
            checks++;
            if (f_a !== (last_e == 7) || act_a !== (last_e == 7)) begin
                errors++;
                $display("FAIL food_edge e=%0d got f=%b act=%b want %b", last_e, f_a, act_a, (last_e == 7));
            end
        end
    endtask

    task automatic test_medicine_glitch();
        int pulses_glitch, pulses_steady;
        pulses_glitch = 0; pulses_steady = 0;
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            raw_m = (i < 40) ? (((i / 2) % 2) == 0) : 1'b1;
            tick();
            if (i < 40) pulses_glitch += int'(m_a);
            else        pulses_steady += int'(m_a);
            checks++;
            if (obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL med_model e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
        end
        checks++;
        if (pulses_glitch !== 0) begin
            errors++;
            $display("FAIL med_glitch got %0d pulses want 0", pulses_glitch);
        end
        checks++;
        if (pulses_steady !== 1) begin
            errors++;
            $display("FAIL med_steady got %0d pulses want 1", pulses_steady);
        end
    endtask

    task automatic test_long_press();
        int pulses;
        int lens [3] = '{15, 19, 20};
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            raw_t = 1'b1;
            tick();
            pulses += int'(t_a);
            checks++;
            if (h_a !== (last_e >= 6) || t_a !== (last_e == TEST_E) || obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL test_hold e=%0d got held=%b t=%b hi=%b lo=%b want held=%b t=%b", last_e, h_a, t_a, obs_a, obs_b, (last_e >= 6), (last_e == TEST_E));
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL test_hold_count got %0d pulses want 1", pulses);
        end
        // Shorter holds and the exact-threshold hold.
        for (int h = 0; h < 3; h++) begin
            pulses = 0;
            for (int i = 0; i < lens[h] + 45; i++) begin
                raw_t = (i >= 20) && (i < 20 + lens[h]);
                tick();
                pulses += int'(t_a);
                checks++;
                if (obs_a !== exp_v || obs_b !== exp_v) begin
                    errors++;
                    $display("FAIL test_rehold len=%0d e=%0d got hi=%b lo=%b want %b", lens[h], last_e, obs_a, obs_b, exp_v);
                end
            end
            checks++;
            if (pulses !== ((!LONG_EN || lens[h] >= L) ? 1 : 0)) begin
                errors++;
                $display("FAIL test_rehold_count len=%0d got %0d pulses want %0d", lens[h], pulses, (!LONG_EN || lens[h] >= L) ? 1 : 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            raw_f = (i < 15);
            raw_m = (i < 15);
            tick();
            checks++;
            if (f_a !== (last_e == 7) || m_a !== (last_e == 7) || act_a !== (last_e == 7) ||
                obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL simultaneous e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int rem [3];
        logic val [3];
        int pulses;
        pulses = 0;
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            rem[c] = 0;
            val[c] = 1'b0;
        end
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (rem[c] == 0) begin
                    val[c] = logic'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
                end
                rem[c]--;
            end
            raw_f = val[0]; raw_m = val[1]; raw_t = val[2];
            tick();
            pulses += int'(act_a);
            checks++;
            if (obs_a !== exp_v || obs_b !== exp_v) begin
                errors++;
                $display("FAIL random e=%0d got hi=%b lo=%b want %b", last_e, obs_a, obs_b, exp_v);
            end
        end
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL random_activity got 0 pulses want at least 1");
        end
    endtask

    initial begin
        reset = 1'b1;
        raw_f = 1'b0; raw_m = 1'b0; raw_t = 1'b0;
        test_reset();
        test_food();
        test_medicine_glitch();
        test_long_press();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
